locked_reg_bank: RTL and testbench
==================================

# locked_reg_bank

Parametrised bank of lockable configuration registers. It succeeds the single 16-bit locked register with per-entry sticky locks, a qualified debug override, and violation reporting. It sits on the configuration write path of security-sensitive blocks. Software sets each lock once; the lock is cleared only by reset.

## Interface
- WIDTH, 16, data width of each register
- DEPTH, 4, number of registers (2..16, need not be a power of 2)
- ADDR_W, 2, address width; must satisfy 2^ADDR_W >= DEPTH
- RESET_VAL, 0, reset value of every register
- ARM_CYCLES, 4, consecutive cycles debug_unlocked must be high before the override takes effect (1..15)
- CNT_W, 8, width of the violation counter

Ports:
- clk  in  1  clock, all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- write  in  1  write strobe for register addr
- addr  in  ADDR_W  register select, for both write and read
- Data_in  in  WIDTH  write data
- lock_req  in  1  sets the sticky lock of register addr
- debug_unlocked  in  1  debug override request
- Data_out  out  WIDTH  combinational read of register addr
- lock_vec  out  DEPTH  current lock bits
- dbg_active  out  1  the debug override is in effect
- violation  out  1  one-cycle pulse after a blocked write
- viol_count  out  CNT_W  saturating count of blocked writes

## Operation
- Reset values: all registers = RESET_VAL; lock_vec = 0; dbg_active = 0; violation = 0; viol_count = 0; debug FSM = DBG_OFF with its arm counter at 0.
- Write rule at a rising edge where write=1 and addr < DEPTH:
  - Register addr loads Data_in if lock_vec[addr]=0 (pre-edge value) or dbg_active=1.
  - Otherwise the register keeps its value, violation=1 for the following cycle, and viol_count increments, saturating at 2^CNT_W-1.
- Lock rule: lock_req=1 with addr < DEPTH sets lock_vec[addr]. A lock bit is never cleared except by reset. lock_req to an already locked entry has no effect.
- Write and lock_req in the same cycle to an unlocked entry: the write succeeds, and the lock is set at the same edge.
- addr >= DEPTH: write and lock_req are ignored with no violation, and Data_out = 0.
- Data_out = register[addr], combinational. It shows the new value in the cycle after a successful write.
- Debug FSM:
  - DBG_OFF: the arm counter is 0. If debug_unlocked=1 the FSM goes to DBG_ARM with the counter at 1.
  - DBG_ARM: while debug_unlocked=1 the counter increments. When the counter reaches ARM_CYCLES the FSM goes to DBG_ON. If debug_unlocked=0 it returns to DBG_OFF and the counter is cleared.
  - DBG_ON: dbg_active=1. If debug_unlocked=0 the FSM goes to DBG_OFF at that edge.
  - With ARM_CYCLES=1 the FSM goes directly from DBG_OFF to DBG_ON.
- dbg_active does not clear lock bits. It only bypasses them for writes.

## Timing
- Write latency: 1 edge. Lock latency: 1 edge.
- violation is registered. It is high for exactly the one cycle after a blocked-write edge, and consecutive blocked writes hold it high.
- dbg_active rises at the ARM_CYCLES-th consecutive edge at which debug_unlocked is sampled high. It falls at the first edge at which debug_unlocked is sampled low.
- Reset asserted mid-operation immediately clears registers, locks, the FSM, the counter and violation, without waiting for a clock edge.

## Configuration
- LOCKED_REG_BANK_DEBUG_EN:
  - Defined: the debug FSM and override behave as described above.
  - Undefined: the FSM is not built, debug_unlocked is ignored, and dbg_active is tied to 0. Locked entries can then only be changed through reset.

## Test plan
- Reset, then write 0x1010 to addr 0 -> Data_out=0x1010 next cycle; lock_vec=0; violation=0.
- Write 0x0010 with lock_req=1 at addr 1, then write 0x1111 at addr 1 -> Data_out stays 0x0010; lock_vec=4'b0010; violation pulses 1 cycle; viol_count=1.
- Hold debug_unlocked=1 for 3 edges and write 0x1101 to locked addr 1 -> blocked, viol_count=2. Hold it for a 4th edge: dbg_active=1; then write 0x1101 -> accepted, Data_out=0x1101.
- Drop debug_unlocked for 1 cycle, then raise it again -> dbg_active=0; the next write to addr 1 is blocked until 4 more consecutive high edges.
- Issue 260 blocked writes with CNT_W=8 -> viol_count saturates at 255.
- Assert resetn=0 mid-sequence -> all registers 0, lock_vec=0, dbg_active=0; afterwards a write of 0x0011 to addr 1 is accepted. With LOCKED_REG_BANK_DEBUG_EN undefined, repeat scenario 3 -> every write is blocked and dbg_active stays 0.

Source files
------------

// File: rtl/locked_reg_bank.sv
// locked_reg_bank
// ---------------------------------------------------------------------------
// Bank of DEPTH configuration registers, each guarded by a sticky lock bit.
// A lock is set by lock_req and is cleared only by reset. A write to a
// locked entry is blocked. A blocked write raises a one-cycle violation
// pulse and bumps a saturating violation counter. A qualified debug
// override can bypass the locks for writes only.
//
// Optional feature: define LOCKED_REG_BANK_DEBUG_EN to build the debug
// override FSM. Without that macro, debug_unlocked is ignored and
// dbg_active is tied low.
//
// Ports
//   clk            rising-edge clock for all state
//   resetn         asynchronous active-low reset
//   write          write strobe for register addr
//   addr           register select for write, lock and read
//   Data_in        write data
//   lock_req       sets the sticky lock of register addr
//   debug_unlocked debug override request (must be held ARM_CYCLES edges)
//   Data_out       combinational read of register addr (0 when addr >= DEPTH)
//   lock_vec       current lock bits
//   dbg_active     debug override in effect
//   violation      one-cycle pulse after a blocked write
//   viol_count     saturating count of blocked writes
// ---------------------------------------------------------------------------
module locked_reg_bank #(
   parameter int               WIDTH      = 16,
   parameter int               DEPTH      = 4,
   parameter int               ADDR_W     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
   parameter int               ARM_CYCLES = 4,
   parameter int               CNT_W      = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  Data_in,
   input  logic              lock_req,
   input  logic              debug_unlocked,
   output logic [WIDTH-1:0]  Data_out,
   output logic [DEPTH-1:0]  lock_vec,
   output logic              dbg_active,
   output logic              violation,
   output logic [CNT_W-1:0]  viol_count
);

   // Saturating increment for the violation counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1'b1);
      end
   endfunction

   logic [WIDTH-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0] lock_vec_r;
   logic             violation_r;
   logic [CNT_W-1:0] viol_cnt_r;

   logic             addr_ok_s;
   logic [DEPTH-1:0] sel_s;
   logic             sel_locked_s;
   logic             hit_s;
   logic             wr_ok_s;
   logic             blocked_s;
   logic [WIDTH-1:0] rd_data_s;
   logic             dbg_active_s;

   // Compare in ADDR_W+1 bits so DEPTH == 2^ADDR_W does not wrap to zero.
   assign addr_ok_s = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

   // One-hot entry select; all zero for out-of-range addresses.
   always_comb begin
      sel_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (addr_ok_s && (addr == ADDR_W'(i))) begin
            sel_s[i] = 1'b1;
         end else begin
            sel_s[i] = 1'b0;
         end
      end
   end

   // Read mux built as an AND-OR so that an empty select reads as zero.
   always_comb begin
      rd_data_s = {WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         rd_data_s = rd_data_s | ({WIDTH{sel_s[i]}} & regs_r[i]);
      end
   end

   // Write qualification uses the pre-edge lock bit and pre-edge override.
   always_comb begin
      hit_s        = |sel_s;
      sel_locked_s = |(sel_s & lock_vec_r);
      wr_ok_s      = 1'b0;
      blocked_s    = 1'b0;
      if (write && hit_s) begin
         wr_ok_s   = !sel_locked_s || dbg_active_s;
         blocked_s = sel_locked_s && !dbg_active_s;
      end else begin
         wr_ok_s   = 1'b0;
         blocked_s = 1'b0;
      end
   end

   // Register storage: load Data_in on a qualified write.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok_s && sel_s[i]) begin
               regs_r[i] <= Data_in;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // Sticky lock bits: only ever set here, cleared by reset alone.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_vec_r <= {DEPTH{1'b0}};
      end else begin
         lock_vec_r <= lock_vec_r | (sel_s & {DEPTH{lock_req}});
      end
   end

   // Violation pulse and saturating counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         violation_r <= 1'b0;
         viol_cnt_r  <= {CNT_W{1'b0}};
      end else begin
         violation_r <= blocked_s;
         if (blocked_s) begin
            viol_cnt_r <= sat_inc(viol_cnt_r);
         end else begin
            viol_cnt_r <= viol_cnt_r;
         end
      end
   end

`ifdef LOCKED_REG_BANK_DEBUG_EN
   typedef enum logic [1:0] {
      DBG_OFF = 2'b00,
      DBG_ARM = 2'b01,
      DBG_ON  = 2'b10
   } dbg_state_t;

   localparam logic [3:0] ARM_L = 4'(ARM_CYCLES);

   dbg_state_t state_r;
   dbg_state_t state_nxt_s;
   logic [3:0] arm_cnt_r;
   logic [3:0] arm_cnt_nxt_s;
   logic       dbg_active_r;

   // Debug FSM state, arm counter and registered override flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= DBG_OFF;
         arm_cnt_r    <= 4'd0;
         dbg_active_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         arm_cnt_r    <= arm_cnt_nxt_s;
         dbg_active_r <= (state_nxt_s == DBG_ON);
      end
   end

   // Debug FSM next state: ARM_CYCLES consecutive high samples arm it, any
   // low sample disarms it immediately.
   always_comb begin
      state_nxt_s   = state_r;
      arm_cnt_nxt_s = arm_cnt_r;
      case (state_r)
         DBG_OFF: begin
            if (debug_unlocked) begin
               arm_cnt_nxt_s = 4'd1;
               if (ARM_L == 4'd1) begin
                  state_nxt_s = DBG_ON;
               end else begin
                  state_nxt_s = DBG_ARM;
               end
            end else begin
               state_nxt_s   = DBG_OFF;
               arm_cnt_nxt_s = 4'd0;
            end
         end
         DBG_ARM: begin
            if (debug_unlocked) begin
               arm_cnt_nxt_s = arm_cnt_r + 4'd1;
               if ((arm_cnt_r + 4'd1) == ARM_L) begin
                  state_nxt_s = DBG_ON;
               end else begin
                  state_nxt_s = DBG_ARM;
               end
            end else begin
               state_nxt_s   = DBG_OFF;
               arm_cnt_nxt_s = 4'd0;
            end
         end
         DBG_ON: begin
            if (debug_unlocked) begin
               state_nxt_s = DBG_ON;
            end else begin
               state_nxt_s   = DBG_OFF;
               arm_cnt_nxt_s = 4'd0;
            end
         end
         default: begin
            state_nxt_s   = DBG_OFF;
            arm_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   assign dbg_active_s = dbg_active_r;
`else
   logic unused_dbg_s;
   assign unused_dbg_s = debug_unlocked;
   assign dbg_active_s = 1'b0;
`endif

   assign Data_out   = rd_data_s;
   assign lock_vec   = lock_vec_r;
   assign dbg_active = dbg_active_s;
   assign violation  = violation_r;
   assign viol_count = viol_cnt_r;

endmodule

// File: tb/tb_locked_reg_bank.sv
// Directed self-checking bench for locked_reg_bank. The main instance uses
// default parameters. A second instance with DEPTH=5 / ADDR_W=3 exercises
// out-of-range addresses. Expectations follow LOCKED_REG_BANK_DEBUG_EN.
module tb_locked_reg_bank;

`ifdef LOCKED_REG_BANK_DEBUG_EN
   localparam bit DBG = 1'b1;
`else
   localparam bit DBG = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        write;
   logic [1:0]  addr;
   logic [2:0]  addr2;
   logic [15:0] data_in;
   logic        lock_req;
   logic        debug_unlocked;

   logic [15:0] data_out;
   logic [3:0]  lock_vec;
   logic        dbg_active;
   logic        violation;
   logic [7:0]  viol_count;

   logic [15:0] data_out2;
   logic [4:0]  lock_vec2;
   logic        dbg_active2;
   logic        violation2;
   logic [7:0]  viol_count2;

   int n_assert = 0;
   int n_fail   = 0;

   locked_reg_bank dut (
      .clk(clk), .resetn(resetn), .write(write), .addr(addr),
      .Data_in(data_in), .lock_req(lock_req), .debug_unlocked(debug_unlocked),
      .Data_out(data_out), .lock_vec(lock_vec), .dbg_active(dbg_active),
      .violation(violation), .viol_count(viol_count)
   );

   locked_reg_bank #(.DEPTH(5), .ADDR_W(3)) dut2 (
      .clk(clk), .resetn(resetn), .write(write), .addr(addr2),
      .Data_in(data_in), .lock_req(lock_req), .debug_unlocked(debug_unlocked),
      .Data_out(data_out2), .lock_vec(lock_vec2), .dbg_active(dbg_active2),
      .violation(violation2), .viol_count(viol_count2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; write = 1'b0; addr = 2'd0; addr2 = 3'd0;
      data_in = 16'h0000; lock_req = 1'b0; debug_unlocked = 1'b0;

      // Reset state
      #2;
      chk("rst_data",  32'(data_out),   32'h0);
      chk("rst_lock",  32'(lock_vec),   32'h0);
      chk("rst_dbg",   32'(dbg_active), 32'h0);
      chk("rst_viol",  32'(violation),  32'h0);
      chk("rst_cnt",   32'(viol_count), 32'h0);
      #10 resetn = 1'b1;

      // Plain write to unlocked addr 0
      write = 1'b1; addr = 2'd0; data_in = 16'h1010;
      tick();
      write = 1'b0;
      chk("wr0_data", 32'(data_out),  32'h1010);
      chk("wr0_lock", 32'(lock_vec),  32'h0);
      chk("wr0_viol", 32'(violation), 32'h0);

      // Write and lock in the same cycle: write lands, lock set
      write = 1'b1; lock_req = 1'b1; addr = 2'd1; data_in = 16'h0010;
      tick();
      write = 1'b0; lock_req = 1'b0;
      chk("wl1_data", 32'(data_out),  32'h0010);
      chk("wl1_lock", 32'(lock_vec),  32'h2);
      chk("wl1_viol", 32'(violation), 32'h0);

      // Blocked write to locked addr 1
      write = 1'b1; data_in = 16'h1111;
      tick();
      write = 1'b0;
      chk("blk_data", 32'(data_out),   32'h0010);
      chk("blk_viol", 32'(violation),  32'h1);
      chk("blk_cnt",  32'(viol_count), 32'h1);
      tick();
      chk("blk_pulse_end", 32'(violation), 32'h0);

      // Three armed edges, then a write at the fourth: still blocked
      debug_unlocked = 1'b1;
      tick(); tick(); tick();
      chk("arm3_dbg", 32'(dbg_active), 32'h0);
      write = 1'b1; data_in = 16'h1101;
      tick();
      write = 1'b0;
      chk("arm4_data", 32'(data_out),   32'h0010);
      chk("arm4_cnt",  32'(viol_count), 32'h2);
      chk("arm4_dbg",  32'(dbg_active), DBG ? 32'h1 : 32'h0);

      // Override active: write to locked addr 1 accepted
      write = 1'b1; data_in = 16'h1101;
      tick();
      write = 1'b0;
      chk("ovr_data", 32'(data_out),   DBG ? 32'h1101 : 32'h0010);
      chk("ovr_viol", 32'(violation),  DBG ? 32'h0 : 32'h1);
      chk("ovr_cnt",  32'(viol_count), DBG ? 32'h2 : 32'h3);
      chk("ovr_lock", 32'(lock_vec),   32'h2);

      // Drop for one edge: override off immediately
      debug_unlocked = 1'b0;
      tick();
      chk("drop_dbg",  32'(dbg_active), 32'h0);
      chk("drop_viol", 32'(violation),  32'h0);

      // Re-arm with writes on every edge: four blocked, held violation
      debug_unlocked = 1'b1; write = 1'b1; data_in = 16'h2222;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("rearm_viol", 32'(violation), 32'h1);
         chk("rearm_data", 32'(data_out),  DBG ? 32'h1101 : 32'h0010);
      end
      chk("rearm_cnt", 32'(viol_count), DBG ? 32'h6 : 32'h7);
      chk("rearm_dbg", 32'(dbg_active), DBG ? 32'h1 : 32'h0);
      tick();
      chk("rearm_wr_data", 32'(data_out),   DBG ? 32'h2222 : 32'h0010);
      chk("rearm_wr_cnt",  32'(viol_count), DBG ? 32'h6 : 32'h8);
      write = 1'b0; debug_unlocked = 1'b0;
      tick();

      // Saturation: 260 blocked writes
      write = 1'b1; data_in = 16'h5A5A;
      for (int k = 0; k < 260; k++) begin
         tick();
      end
      write = 1'b0;
      chk("sat_cnt",  32'(viol_count), 32'hFF);
      chk("sat_viol", 32'(violation),  32'h1);

      // Relocking a locked entry is a no-op; lock addr 3 alone
      lock_req = 1'b1; addr = 2'd1;
      tick();
      chk("relock_vec", 32'(lock_vec), 32'h2);
      addr = 2'd3;
      tick();
      lock_req = 1'b0;
      chk("lock3_vec",  32'(lock_vec), 32'hA);
      chk("lock3_data", 32'(data_out), 32'h0);
      chk("sat_hold",   32'(viol_count), 32'hFF);

      // Mid-sequence async reset after arming and a blocked write
      addr = 2'd1; debug_unlocked = 1'b1;
      tick(); tick(); tick();
      write = 1'b1; data_in = 16'h7777;
      tick();
      write = 1'b0;
      chk("prerst_viol", 32'(violation),  32'h1);
      chk("prerst_dbg",  32'(dbg_active), DBG ? 32'h1 : 32'h0);
      #3 resetn = 1'b0;
      #1;
      chk("mrst_data", 32'(data_out),   32'h0);
      chk("mrst_lock", 32'(lock_vec),   32'h0);
      chk("mrst_dbg",  32'(dbg_active), 32'h0);
      chk("mrst_viol", 32'(violation),  32'h0);
      chk("mrst_cnt",  32'(viol_count), 32'h0);
      debug_unlocked = 1'b0;
      #2 resetn = 1'b1;
      write = 1'b1; addr = 2'd1; data_in = 16'h0011;
      tick();
      write = 1'b0;
      chk("postrst_data", 32'(data_out),  32'h0011);
      chk("postrst_viol", 32'(violation), 32'h0);

      // Out-of-range addresses on the DEPTH=5 instance
      #2 resetn = 1'b0;
      #2 resetn = 1'b1;
      addr = 2'd0;
      write = 1'b1; lock_req = 1'b1; addr2 = 3'd5; data_in = 16'hBEEF;
      tick();
      chk("oor_data", 32'(data_out2),   32'h0);
      chk("oor_lock", 32'(lock_vec2),   32'h0);
      chk("oor_viol", 32'(violation2),  32'h0);
      addr2 = 3'd4; data_in = 16'hABCD;
      tick();
      lock_req = 1'b0; data_in = 16'h1234;
      chk("top_data", 32'(data_out2), 32'hABCD);
      chk("top_lock", 32'(lock_vec2), 32'h10);
      tick();
      write = 1'b0;
      chk("top_blk_data", 32'(data_out2),   32'hABCD);
      chk("top_blk_viol", 32'(violation2),  32'h1);
      chk("top_blk_cnt",  32'(viol_count2), 32'h1);
      addr2 = 3'd7;
      #1;
      chk("oor7_data", 32'(data_out2), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
